sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 87 ++++++++
 tb/tb_sync_fifo_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
module sync_fifo_param #(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Bad geometry or thresholds that the count can never satisfy stop elaboration.
    if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_cfg_err
        $error("sync_fifo_param: illegal configuration WIDTH=%0d DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
               WIDTH, DEPTH, AF_LEVEL, AE_LEVEL);
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             wa;
    logic             ra;

    assign full         = (cnt == DEPTH_C);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign count        = cnt;

    // A read on a full FIFO frees a slot in the same edge; an empty FIFO never bypasses.
    assign wa = wr_en & (~full | rd_en);
    assign ra = rd_en & ~empty;

    // Storage is left unreset; its contents are meaningless after rst anyway.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wp] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en & ~wa;
            underflow <= rd_en & ~ra;
            if (wa) begin
                wp <= wp + 1'b1;
            end
            if (ra) begin
                out <= mem[rp];
                rp  <= rp + 1'b1;
            end
            if (wa & ~ra) begin
                cnt <= cnt + 1'b1;
            end else if (ra & ~wa) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomized and directed bench for sync_fifo_param against a queue-based model,
// plus a small-geometry instance for the parameter sweep.
module tb_sync_fifo_param;

    localparam int W  = 10;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] din;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         full;
    logic         empty;
    logic         afull;
    logic         aempty;
    logic [4:0]   count;
    logic         ovf;
    logic         unf;

    logic         rst_s;
    logic [7:0]   in_s;
    logic         wr_s;
    logic         rd_s;
    logic [7:0]   out_s;
    logic         full_s;
    logic         empty_s;
    logic         af_s;
    logic         ae_s;
    logic [2:0]   count_s;
    logic         ovf_s;
    logic         unf_s;

    sync_fifo_param u_dut (
        .clk(clk), .rst(rst), .in(din), .wr_en(wr_en), .rd_en(rd_en), .out(dout),
        .full(full), .empty(empty), .almost_full(afull), .almost_empty(aempty),
        .count(count), .overflow(ovf), .underflow(unf)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(0)) u_dut_s (
        .clk(clk), .rst(rst_s), .in(in_s), .wr_en(wr_s), .rd_en(rd_s), .out(out_s),
        .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
        .count(count_s), .overflow(ovf_s), .underflow(unf_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the FIFO contents as a queue, plus last read word and error pulses.
    logic [W-1:0] q[$];
    logic [W-1:0] out_m;
    logic         ovf_m;
    logic         unf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        out_m = '0;
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic check_all(input string ph);
        int n;
        n = q.size();
        chk({ph, ":out"},    32'(dout),   32'(out_m));
        chk({ph, ":count"},  32'(count),  32'(n));
        chk({ph, ":full"},   32'(full),   32'(n == D));
        chk({ph, ":empty"},  32'(empty),  32'(n == 0));
        chk({ph, ":afull"},  32'(afull),  32'(n >= AF));
        chk({ph, ":aempty"}, 32'(aempty), 32'(n <= AE));
        chk({ph, ":ovf"},    32'(ovf),    32'(ovf_m));
        chk({ph, ":unf"},    32'(unf),    32'(unf_m));
    endtask

    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d, input string ph);
        bit wacc;
        bit racc;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        racc = r && (q.size() > 0);
        wacc = w && ((q.size() < D) || r);
        if (racc) out_m = q.pop_front();
        if (wacc) q.push_back(d);
        ovf_m = w && !wacc;
        unf_m = r && !racc;
        #1;
        check_all(ph);
    endtask

    initial begin
        rst = 1'b1; rst_s = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; din = '0;
        wr_s = 1'b0; rd_s = 1'b0; in_s = '0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0; rst_s = 1'b0;

        // Fill / overflow / drain / underflow
        for (int i = 1; i <= D; i++) cycle(1'b1, 1'b0, W'(i), "fill");
        cycle(1'b1, 1'b0, 10'h3FF, "ovf");
        cycle(1'b0, 1'b0, '0, "ovf_clr");
        for (int i = 1; i <= D; i++) cycle(1'b0, 1'b1, '0, "drain");
        chk("drain_last", 32'(dout), 32'h010);
        cycle(1'b0, 1'b1, '0, "unf");
        cycle(1'b0, 1'b0, '0, "unf_clr");

        // Simultaneous at empty: write accepted, read rejected
        cycle(1'b1, 1'b1, 10'h155, "sim_empty");
        cycle(1'b0, 1'b1, '0, "sim_empty_rd");
        chk("sim_empty_data", 32'(dout), 32'h155);

        // Simultaneous at full
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'($urandom), "fill2");
        cycle(1'b1, 1'b1, 10'h2AA, "sim_full");
        for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, '0, "drain2");
        chk("sim_full_last", 32'(dout), 32'h2AA);

        // Streaming 3 writes / 3 reads with the pointers offset by two
        cycle(1'b1, 1'b0, W'($urandom), "stream_pre");
        cycle(1'b1, 1'b0, W'($urandom), "stream_pre");
        for (int i = 0; i < 40; i++) begin
            if ((i % 6) < 3) cycle(1'b1, 1'b0, W'($urandom), "stream");
            else             cycle(1'b0, 1'b1, '0, "stream");
        end

        // Random traffic, alternately biased towards full and towards empty
        for (int blk = 0; blk < 6; blk++) begin
            int bias;
            bias = (blk % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 250; i++) begin
                cycle($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                      W'($urandom), "rand");
            end
        end

        // Asynchronous reset in mid-cycle with count=5
        while (q.size() > 0) cycle(1'b0, 1'b1, '0, "pre_rst_drain");
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(10'h101 + i), "pre_rst_fill");
        cycle(1'b0, 1'b1, '0, "pre_rst_rd");
        wr_en = 1'b0; rd_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        #2;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 10'h0AB, "post_rst_wr");
        cycle(1'b0, 1'b1, '0, "post_rst_rd");

        // Parameter sweep instance: DEPTH=4, AF_LEVEL=3, AE_LEVEL=0
        wr_en = 1'b0; rd_en = 1'b0;
        chk("s_reset_count", 32'(count_s), 32'd0);
        chk("s_reset_ae", 32'(ae_s), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            wr_s = 1'b1; rd_s = 1'b0; in_s = 8'(8'hA0 + i);
            @(posedge clk);
            #1;
            chk("s_fill_count", 32'(count_s), 32'(i));
            chk("s_fill_af",    32'(af_s),    32'(i >= 3));
            chk("s_fill_ae",    32'(ae_s),    32'd0);
            chk("s_fill_full",  32'(full_s),  32'(i == 4));
        end
        in_s = 8'hFF;
        @(posedge clk);
        #1;
        chk("s_ovf", 32'(ovf_s), 32'd1);
        chk("s_ovf_count", 32'(count_s), 32'd4);
        wr_s = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rd_s = 1'b1;
            @(posedge clk);
            #1;
            chk("s_drain_out",   32'(out_s),   32'(8'hA0 + i));
            chk("s_drain_count", 32'(count_s), 32'(4 - i));
            chk("s_drain_ae",    32'(ae_s),    32'(i == 4));
            chk("s_drain_af",    32'(af_s),    32'((4 - i) >= 3));
            chk("s_drain_empty", 32'(empty_s), 32'(i == 4));
        end
        @(posedge clk);
        #1;
        chk("s_unf", 32'(unf_s), 32'd1);
        chk("s_unf_out", 32'(out_s), 32'hA4);
        rd_s = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
